// File: rtl/vcr_ovc_pkg.sv
// Shared types for the output-VC state tracker: per-OVC state encoding and credit counter width.
package vcr_ovc_pkg;

  typedef enum logic [1:0] {
    OVC_IDLE  = 2'd0,
    OVC_BUSY  = 2'd1,
    OVC_DRAIN = 2'd2
  } ovc_state_e;

  // Counter must hold 0..depth inclusive; never narrower than one bit.
  function automatic int unsigned cred_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vcr_ovc_state_tracker.sv
// One output VC: downstream credit counter, IDLE/BUSY/DRAIN state machine and eligibility decode.
// Optional sticky misuse flag under VCR_OVC_STATE_CHECK_EN.
module vcr_ovc_state_tracker
  import vcr_ovc_pkg::*;
#(
  parameter int unsigned buffer_size          = 8,
  parameter bit          atomic_vc_allocation = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic gnt,
  input  logic flit_valid,
  input  logic flit_tail,
  input  logic cred_valid,
  output logic elig,
  output logic cred_avail,
  output logic empty
`ifdef VCR_OVC_STATE_CHECK_EN
  ,
  output logic error
`endif
);

  localparam int unsigned CW = cred_width(buffer_size);
  localparam logic [CW-1:0] CNT_FULL = CW'(buffer_size);

  logic [CW-1:0] cnt_q, cnt_d;
  ovc_state_e    state_q, state_d;

  // Credit count: a flit and a credit in the same cycle cancel; saturate at both ends.
  always_comb begin
    cnt_d = cnt_q;
    if (flit_valid && !cred_valid && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end else if (cred_valid && !flit_valid && (cnt_q != CNT_FULL)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // DRAIN exits as soon as the count is, or is about to become, full.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OVC_IDLE: begin
        if (gnt) state_d = OVC_BUSY;
      end
      OVC_BUSY: begin
        if (flit_valid && flit_tail) begin
          state_d = atomic_vc_allocation ? OVC_DRAIN : OVC_IDLE;
        end
      end
      OVC_DRAIN: begin
        if ((cnt_q == CNT_FULL) || (cnt_d == CNT_FULL)) state_d = OVC_IDLE;
      end
      default: state_d = OVC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OVC_IDLE;
      cnt_q   <= CNT_FULL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign empty      = (cnt_q == CNT_FULL);
  assign cred_avail = (cnt_q != '0);
  assign elig       = (state_q == OVC_IDLE) && (atomic_vc_allocation ? empty : cred_avail);

`ifdef VCR_OVC_STATE_CHECK_EN
  logic err_q;
  logic err_event;

  assign err_event = (flit_valid && !cred_valid && (cnt_q == '0))
                   || (cred_valid && !flit_valid && (cnt_q == CNT_FULL))
                   || (gnt && !elig)
                   || (flit_valid && (state_q != OVC_BUSY));

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_event) begin
      err_q <= 1'b1;
    end
  end

  assign error = err_q;
`endif

endmodule

// File: rtl/vcr_ovc_state_ctrl.sv
// Router output-stage OVC state tracking: one tracker per (port, VC), flattened port-major vectors.
// Optional per-OVC misuse flags under VCR_OVC_STATE_CHECK_EN.
module vcr_ovc_state_ctrl
  import vcr_ovc_pkg::*;
#(
  parameter int unsigned num_message_classes  = 2,
  parameter int unsigned num_resource_classes = 2,
  parameter int unsigned num_vcs_per_class    = 1,
  parameter int unsigned num_ports            = 5,
  parameter int unsigned buffer_size          = 8,
  parameter bit          atomic_vc_allocation = 1'b1,
  localparam int unsigned num_vcs  = num_message_classes * num_resource_classes * num_vcs_per_class,
  localparam int unsigned num_ovcs = num_ports * num_vcs
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [num_ovcs-1:0] gnt_op_ovc,
  input  logic [num_ovcs-1:0] flit_valid_op_ovc,
  input  logic [num_ovcs-1:0] flit_tail_op_ovc,
  input  logic [num_ovcs-1:0] cred_valid_op_ovc,
  output logic [num_ovcs-1:0] elig_op_ovc,
  output logic [num_ovcs-1:0] cred_avail_op_ovc,
  output logic [num_ovcs-1:0] empty_op_ovc
`ifdef VCR_OVC_STATE_CHECK_EN
  ,
  output logic [num_ovcs-1:0] error_op_ovc
`endif
);

  for (genvar i = 0; i < num_ovcs; i++) begin : g_ovc
    vcr_ovc_state_tracker #(
      .buffer_size          (buffer_size),
      .atomic_vc_allocation (atomic_vc_allocation)
    ) u_tracker (
      .clk        (clk),
      .reset      (reset),
      .gnt        (gnt_op_ovc[i]),
      .flit_valid (flit_valid_op_ovc[i]),
      .flit_tail  (flit_tail_op_ovc[i]),
      .cred_valid (cred_valid_op_ovc[i]),
      .elig       (elig_op_ovc[i]),
      .cred_avail (cred_avail_op_ovc[i]),
      .empty      (empty_op_ovc[i])
`ifdef VCR_OVC_STATE_CHECK_EN
      ,
      .error      (error_op_ovc[i])
`endif
    );
  end

endmodule

// File: tb/tb_vcr_ovc_state_ctrl.sv
// Scoreboard bench: an atomic and a non-atomic instance share stimulus; expected vectors are queued per cycle.
// Error-flag checks are included when VCR_OVC_STATE_CHECK_EN is defined.
module tb_vcr_ovc_state_ctrl;

  localparam int unsigned N = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [N-1:0] gnt, fv, ft, cv;
  logic [N-1:0] a_elig, a_cav, a_emp, b_elig, b_cav, b_emp;
  logic [N-1:0] a_err, b_err;

  vcr_ovc_state_ctrl #(.atomic_vc_allocation(1'b1)) u_dut_a (
    .clk               (clk),
    .reset             (reset),
    .gnt_op_ovc        (gnt),
    .flit_valid_op_ovc (fv),
    .flit_tail_op_ovc  (ft),
    .cred_valid_op_ovc (cv),
    .elig_op_ovc       (a_elig),
    .cred_avail_op_ovc (a_cav),
    .empty_op_ovc      (a_emp)
`ifdef VCR_OVC_STATE_CHECK_EN
    ,
    .error_op_ovc      (a_err)
`endif
  );

  vcr_ovc_state_ctrl #(.atomic_vc_allocation(1'b0)) u_dut_b (
    .clk               (clk),
    .reset             (reset),
    .gnt_op_ovc        (gnt),
    .flit_valid_op_ovc (fv),
    .flit_tail_op_ovc  (ft),
    .cred_valid_op_ovc (cv),
    .elig_op_ovc       (b_elig),
    .cred_avail_op_ovc (b_cav),
    .empty_op_ovc      (b_emp)
`ifdef VCR_OVC_STATE_CHECK_EN
    ,
    .error_op_ovc      (b_err)
`endif
  );

`ifndef VCR_OVC_STATE_CHECK_EN
  assign a_err = '0;
  assign b_err = '0;
`endif

  typedef struct {
    int           cyc;
    string        name;
    logic [N-1:0] elig_a, elig_b, cav, emp, err_a, err_b;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic [N-1:0] x_elig_a, x_elig_b, x_cav, x_emp, x_err_a, x_err_b;

  task automatic cmp(input string name, input string sig, input logic [N-1:0] act,
                     input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s actual=%h required=%h", name, sig, act, req);
    end
  endtask

  // Inputs are set at posedge+1; the following edge latches them and the expectation is queued.
  task automatic step(input string name);
    exp_t e;
    @(posedge clk);
    cyc++;
    e.cyc    = cyc;
    e.name   = name;
    e.elig_a = x_elig_a;
    e.elig_b = x_elig_b;
    e.cav    = x_cav;
    e.emp    = x_emp;
    e.err_a  = x_err_a;
    e.err_b  = x_err_b;
    sb.push_back(e);
    #1;
    reset = 1'b0;
    gnt = '0; fv = '0; ft = '0; cv = '0;
  endtask

  task automatic expect_reset_state();
    x_elig_a = '1; x_elig_b = '1; x_cav = '1; x_emp = '1;
    x_err_a = '0; x_err_b = '0;
  endtask

  // Monitor: compare both instances against the queued expectation for this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      cmp(e.name, "elig_a", a_elig, e.elig_a);
      cmp(e.name, "elig_b", b_elig, e.elig_b);
      cmp(e.name, "cav_a", a_cav, e.cav);
      cmp(e.name, "cav_b", b_cav, e.cav);
      cmp(e.name, "empty_a", a_emp, e.emp);
      cmp(e.name, "empty_b", b_emp, e.emp);
`ifdef VCR_OVC_STATE_CHECK_EN
      cmp(e.name, "error_a", a_err, e.err_a);
      cmp(e.name, "error_b", b_err, e.err_b);
`endif
    end
  end

  initial begin
    reset = 1'b1;
    gnt = '0; fv = '0; ft = '0; cv = '0;
    expect_reset_state();

    reset = 1'b1; step("reset0");
    reset = 1'b1; step("reset1");
    for (int i = 0; i < 3; i++) step("idle_after_reset");

    // OVC0: grant, three flits (last is tail), then three credits.
    gnt[0] = 1'b1; x_elig_a[0] = 1'b0; x_elig_b[0] = 1'b0; step("gnt_ovc0");
    fv[0] = 1'b1; x_emp[0] = 1'b0; step("flit1_ovc0");
    fv[0] = 1'b1; step("flit2_ovc0");
    fv[0] = 1'b1; ft[0] = 1'b1; x_elig_b[0] = 1'b1; step("tail_ovc0");
    step("drain_hold_ovc0");
    cv[0] = 1'b1; step("cred1_ovc0");
    cv[0] = 1'b1; step("cred2_ovc0");
    cv[0] = 1'b1; x_elig_a[0] = 1'b1; x_emp[0] = 1'b1; step("cred3_full_ovc0");
    step("idle_ovc0");

    // OVC1: drain all eight credits, then flit+credit together at zero.
    gnt[1] = 1'b1; x_elig_a[1] = 1'b0; x_elig_b[1] = 1'b0; step("gnt_ovc1");
    for (int k = 1; k <= 8; k++) begin
      fv[1] = 1'b1;
      x_emp[1] = 1'b0;
      if (k == 8) begin
        ft[1] = 1'b1;
        x_cav[1] = 1'b0;
      end
      step("flit_ovc1");
    end
    fv[1] = 1'b1; cv[1] = 1'b1; x_err_a[1] = 1'b1; x_err_b[1] = 1'b1; step("flit_cred_at_zero");
    cv[1] = 1'b1; x_cav[1] = 1'b1; x_elig_b[1] = 1'b1; step("first_credit_ovc1");
    for (int k = 2; k <= 8; k++) begin
      cv[1] = 1'b1;
      if (k == 8) begin
        x_emp[1] = 1'b1;
        x_elig_a[1] = 1'b1;
      end
      step("credit_ovc1");
    end

    // OVC2: credit at full saturates; one flit then shows seven, not nine.
    cv[2] = 1'b1; x_err_a[2] = 1'b1; x_err_b[2] = 1'b1; step("cred_at_full_ovc2");
    fv[2] = 1'b1; x_emp[2] = 1'b0; x_elig_a[2] = 1'b0; step("flit_after_sat_ovc2");
    cv[2] = 1'b1; x_emp[2] = 1'b1; x_elig_a[2] = 1'b1; step("cred_refill_ovc2");

    // OVC3: single-flit packet with a second grant colliding with the tail.
    gnt[3] = 1'b1; x_elig_a[3] = 1'b0; x_elig_b[3] = 1'b0; step("gnt_ovc3");
    gnt[3] = 1'b1; fv[3] = 1'b1; ft[3] = 1'b1;
    x_emp[3] = 1'b0; x_elig_b[3] = 1'b1; x_err_a[3] = 1'b1; x_err_b[3] = 1'b1;
    step("gnt_and_tail_ovc3");
    step("no_rebusy_ovc3");
    cv[3] = 1'b1; x_emp[3] = 1'b1; x_elig_a[3] = 1'b1; step("cred_ovc3");

    // OVC4: reset mid-packet clears everything.
    gnt[4] = 1'b1; x_elig_a[4] = 1'b0; x_elig_b[4] = 1'b0; step("gnt_ovc4");
    fv[4] = 1'b1; x_emp[4] = 1'b0; step("flit_ovc4");
    reset = 1'b1; expect_reset_state(); step("mid_packet_reset");
    step("post_reset");

    // Grant to a draining OVC on the atomic instance: sticky flag until reset.
    gnt[0] = 1'b1; x_elig_a[0] = 1'b0; x_elig_b[0] = 1'b0; step("gnt2_ovc0");
    fv[0] = 1'b1; ft[0] = 1'b1; x_emp[0] = 1'b0; x_elig_b[0] = 1'b1; step("tail2_ovc0");
    gnt[0] = 1'b1; x_err_a[0] = 1'b1; x_elig_b[0] = 1'b0; step("gnt_in_drain");
    step("err_sticky1");
    step("err_sticky2");
    reset = 1'b1; expect_reset_state(); step("err_reset");

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
